lms7_rx_pkt_packer: RTL and testbench



---
 rtl/lms7_rx_pkt_packer_if.sv | 18 +
 rtl/lms7_rx_pkt_packer.sv | 130 +++++++++++++
 tb/tb_lms7_rx_pkt_packer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms7_rx_pkt_packer_if.sv
// 64-bit AXI-Stream bundle carrying packed RX words to the DMA.
interface lms7_rx_pkt_packer_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/lms7_rx_pkt_packer.sv
// Packs NCH I/Q pairs of 8/12/16-bit samples into a 64-bit AXIS stream
// with byte-accurate burst tails, backpressure and overrun accounting.
module lms7_rx_pkt_packer #(
  parameter int NCH       = 2,
  parameter int DROP_BITS = 16,
  parameter int ACC_BITS  = 192
) (
  input  logic                    in_sdr_clk,
  input  logic                    fe_reset_n,
  input  logic [NCH*32-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [1:0]              in_fmt,
  lms7_rx_pkt_packer_if.master    axis_tx,
  output logic [DROP_BITS-1:0]    drop_cnt,
  output logic                    overrun,
  input  logic                    clr_stats
);
  localparam int FW = $clog2(ACC_BITS + 1);
  localparam int BW = NCH * 32;

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] acc_n;
  logic [ACC_BITS-1:0] beat_ext;
  logic [FW-1:0]       fill;
  logic [FW-1:0]       fill_n;
  logic                flush;
  logic                flush_n;
  logic [1:0]          fmt_active;
  logic [1:0]          fmt_eff;
  logic [BW-1:0]       beat;
  logic [FW:0]         s_bits;
  logic [FW:0]         base;
  logic [FW:0]         room;
  logic [6:0]          take;
  logic [7:0]          keep;
  logic                stop;
  logic                emit;
  logic                accept;
  logic                drop;
  logic                last_out;

  // The format only follows in_fmt between bursts.
  assign stop    = (fmt_active != 2'd0) && (in_fmt == 2'd0);
  assign fmt_eff = (fill == '0 && !flush) ? in_fmt : fmt_active;

  always_comb begin
    beat   = '0;
    s_bits = '0;
    for (int k = 0; k < 2 * NCH; k++) begin
      unique case (fmt_eff)
        2'd1:    beat[8*k +: 8]   = in_data[16*k+4 +: 8];
        2'd2:    beat[12*k +: 12] = in_data[16*k +: 12];
        2'd3:    beat[16*k +: 16] = in_data[16*k +: 16];
        default: ;
      endcase
    end
    unique case (fmt_eff)
      2'd1:    s_bits = (FW+1)'(NCH * 16);
      2'd2:    s_bits = (FW+1)'(NCH * 24);
      2'd3:    s_bits = (FW+1)'(NCH * 32);
      default: s_bits = '0;
    endcase
  end

  always_comb begin
    emit     = !stop
             && (fill >= FW'(64) || (flush && fill != '0))
             && (!axis_tx.tvalid || axis_tx.tready);
    take     = '0;
    if (emit)
      take = (fill >= FW'(64)) ? 7'd64 : fill[6:0];
    base     = {1'b0, fill} - (FW+1)'(take);
    room     = base + s_bits;
    accept   = in_valid && fmt_eff != 2'd0 && !flush && !stop
             && room <= (FW+1)'(ACC_BITS);
    drop     = in_valid && fmt_eff != 2'd0 && !accept && !stop;
    last_out = flush && fill <= FW'(64);
    keep     = (fill >= FW'(64)) ? 8'hFF
             : 8'hFF >> (4'd8 - {1'b0, fill[5:3]});
    beat_ext = ACC_BITS'(beat) << base;
    acc_n    = (acc >> take) | (accept ? beat_ext : '0);
    fill_n   = accept ? room[FW-1:0] : base[FW-1:0];
    flush_n  = flush || (in_last && (accept || drop));
    // A closing word ends the burst even if a late last beat was dropped.
    if (emit && last_out)
      flush_n = 1'b0;
    if (stop) begin
      acc_n   = '0;
      fill_n  = '0;
      flush_n = 1'b0;
    end
  end

  always_ff @(posedge in_sdr_clk) begin
    if (!fe_reset_n) begin
      acc            <= '0;
      fill           <= '0;
      flush          <= 1'b0;
      fmt_active     <= 2'd0;
      axis_tx.tdata  <= '0;
      axis_tx.tkeep  <= '0;
      axis_tx.tvalid <= 1'b0;
      axis_tx.tlast  <= 1'b0;
      drop_cnt       <= '0;
      overrun        <= 1'b0;
    end else begin
      acc        <= acc_n;
      fill       <= fill_n;
      flush      <= flush_n;
      fmt_active <= stop ? 2'd0 : fmt_eff;
      if (emit) begin
        axis_tx.tvalid <= 1'b1;
        axis_tx.tdata  <= acc[63:0];
        axis_tx.tkeep  <= keep;
        axis_tx.tlast  <= last_out;
      end else if (axis_tx.tready) begin
        axis_tx.tvalid <= 1'b0;
      end
      if (clr_stats) begin
        drop_cnt <= '0;
        overrun  <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_lms7_rx_pkt_packer.sv
// Bench: three packers (NCH 1/2/4) against a bit-queue reference model,
// plus directed burst, tail, overrun, stop and reset scenarios.
module tb_lms7_rx_pkt_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] din [3];
  logic         vld [3];
  logic         lst [3];
  logic         rdy [3];
  logic         clr [3];
  logic [1:0]   fmt [3];

  logic         tv [3];
  logic         tl [3];
  logic [63:0]  td [3];
  logic [7:0]   tk [3];
  logic [15:0]  dc [3];
  logic         ov [3];

  logic [15:0]  dc0, dc1;
  logic [2:0]   dc2;
  logic         ov0, ov1, ov2;

  lms7_rx_pkt_packer_if ax0 ();
  lms7_rx_pkt_packer_if ax1 ();
  lms7_rx_pkt_packer_if ax2 ();

  lms7_rx_pkt_packer #(.NCH(1)) u0 (
    .in_sdr_clk(clk), .fe_reset_n(rst_n),
    .in_data(din[0][31:0]), .in_valid(vld[0]),
    .in_last(lst[0]), .in_fmt(fmt[0]), .axis_tx(ax0),
    .drop_cnt(dc0), .overrun(ov0), .clr_stats(clr[0])
  );
  lms7_rx_pkt_packer #(.NCH(2)) u1 (
    .in_sdr_clk(clk), .fe_reset_n(rst_n),
    .in_data(din[1][63:0]), .in_valid(vld[1]),
    .in_last(lst[1]), .in_fmt(fmt[1]), .axis_tx(ax1),
    .drop_cnt(dc1), .overrun(ov1), .clr_stats(clr[1])
  );
  lms7_rx_pkt_packer #(.NCH(4), .DROP_BITS(3)) u2 (
    .in_sdr_clk(clk), .fe_reset_n(rst_n),
    .in_data(din[2]), .in_valid(vld[2]),
    .in_last(lst[2]), .in_fmt(fmt[2]), .axis_tx(ax2),
    .drop_cnt(dc2), .overrun(ov2), .clr_stats(clr[2])
  );

  assign ax0.tready = rdy[0];
  assign ax1.tready = rdy[1];
  assign ax2.tready = rdy[2];
  assign tv[0] = ax0.tvalid;
  assign tv[1] = ax1.tvalid;
  assign tv[2] = ax2.tvalid;
  assign tl[0] = ax0.tlast;
  assign tl[1] = ax1.tlast;
  assign tl[2] = ax2.tlast;
  assign td[0] = ax0.tdata;
  assign td[1] = ax1.tdata;
  assign td[2] = ax2.tdata;
  assign tk[0] = ax0.tkeep;
  assign tk[1] = ax1.tkeep;
  assign tk[2] = ax2.tkeep;
  assign dc[0] = dc0;
  assign dc[1] = dc1;
  assign dc[2] = {13'd0, dc2};
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign ov[2] = ov2;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  function automatic int nch_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic int dmax_of(input int i);
    return (i == 2) ? 7 : 65535;
  endfunction

  // Reference model: the accumulator is a plain queue of bits.
  bit          q [3][$];
  bit          m_flush [3];
  bit          m_val [3];
  bit          m_last [3];
  bit          m_ovr [3];
  logic [1:0]  m_fmt [3];
  logic [63:0] m_data [3];
  logic [7:0]  m_keep [3];
  int          m_dcnt [3];

  int  cyc = 0;
  bit  chk_en = 0;
  int  first_tv [3];
  logic [63:0] wd [3][$];
  logic [7:0]  wk [3][$];
  logic        wl [3][$];

  task automatic model_step(input int i);
    int n, tkn, room, sw;
    bit stop, emit, acc, drop;
    logic [1:0] fe;
    logic [15:0] smp;
    if (!rst_n) begin
      q[i].delete();
      m_flush[i] = 0; m_fmt[i] = 0; m_val[i] = 0;
      m_data[i] = '0; m_keep[i] = '0; m_last[i] = 0;
      m_dcnt[i] = 0; m_ovr[i] = 0;
    end else begin
      n    = q[i].size();
      stop = (m_fmt[i] != 0) && (fmt[i] == 0);
      fe   = (n == 0 && !m_flush[i]) ? fmt[i] : m_fmt[i];
      sw   = (fe == 1) ? 8 : (fe == 2) ? 12 : (fe == 3) ? 16 : 0;
      emit = !stop && (n >= 64 || (m_flush[i] && n > 0))
           && (!m_val[i] || rdy[i]);
      tkn  = emit ? ((n > 64) ? 64 : n) : 0;
      room = n - tkn + nch_of(i) * 2 * sw;
      acc  = vld[i] && fe != 0 && !m_flush[i] && !stop && room <= 192;
      drop = vld[i] && fe != 0 && !acc && !stop;
      if (emit) begin
        m_data[i] = '0;
        for (int b = 0; b < tkn; b++) m_data[i][b] = q[i].pop_front();
        for (int b = 0; b < 8; b++) m_keep[i][b] = (b * 8 < tkn);
        m_last[i] = m_flush[i] && n <= 64;
        m_val[i]  = 1;
      end else if (rdy[i]) begin
        m_val[i] = 0;
      end
      if (acc) begin
        for (int c = 0; c < 2 * nch_of(i); c++) begin
          smp = din[i][16*c +: 16];
          for (int t = 0; t < sw; t++)
            q[i].push_back((fe == 1) ? smp[t+4] : smp[t]);
        end
      end
      if (emit && m_last[i]) m_flush[i] = 0;
      else if ((acc || drop) && lst[i]) m_flush[i] = 1;
      if (stop) begin
        q[i].delete();
        m_flush[i] = 0;
      end
      m_fmt[i] = stop ? 2'd0 : fe;
      if (clr[i]) begin
        m_dcnt[i] = 0;
        m_ovr[i]  = 0;
      end else if (drop) begin
        m_ovr[i] = 1;
        if (m_dcnt[i] < dmax_of(i)) m_dcnt[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) chk_en = 1;
    for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_tvalid", i), 64'(tv[i]), 64'(m_val[i]));
        if (m_val[i]) begin
          chk($sformatf("i%0d_tdata", i), td[i], m_data[i]);
          chk($sformatf("i%0d_tkeep", i), 64'(tk[i]), 64'(m_keep[i]));
          chk($sformatf("i%0d_tlast", i), 64'(tl[i]), 64'(m_last[i]));
        end
        chk($sformatf("i%0d_drop", i), 64'(dc[i]), 64'(m_dcnt[i]));
        chk($sformatf("i%0d_ovr", i), 64'(ov[i]), 64'(m_ovr[i]));
        if (tv[i] === 1'b1 && rdy[i]) begin
          wd[i].push_back(td[i]);
          wk[i].push_back(tk[i]);
          wl[i].push_back(tl[i]);
        end
        if (tv[i] === 1'b1 && first_tv[i] < 0) first_tv[i] = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log(input int i);
    wd[i].delete();
    wk[i].delete();
    wl[i].delete();
  endtask

  logic [127:0] bt [5];
  logic [319:0] bits;
  logic [63:0]  exp_w;
  logic [63:0]  exp8;
  int c0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; vld[i] = 0; lst[i] = 0;
      rdy[i] = 0; clr[i] = 0; fmt[i] = 2'd0;
      first_tv[i] = -1;
    end
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tvalid", 64'(tv[i]), 64'd0);
      chk("rst_drop", 64'(dc[i]), 64'd0);
      chk("rst_ovr", 64'(ov[i]), 64'd0);
    end

    // 16-bit, 4-beat burst on NCH=2
    fmt[1] = 2'd3; rdy[1] = 1; clear_log(1);
    first_tv[1] = -1;
    c0 = cyc;
    for (int b = 0; b < 4; b++) begin
      bt[b] = {$urandom, $urandom, $urandom, $urandom};
      din[1] = bt[b]; vld[1] = 1; lst[1] = (b == 3);
      tick();
    end
    vld[1] = 0; lst[1] = 0;
    tick(6);
    chk("a_latency", 64'(first_tv[1] - c0), 64'd2);
    chk("a_words", 64'(wd[1].size()), 64'd4);
    if (wd[1].size() == 4)
      for (int j = 0; j < 4; j++) begin
        chk("a_data", wd[1][j], bt[j][63:0]);
        chk("a_keep", 64'(wk[1][j]), 64'hFF);
        chk("a_last", 64'(wl[1][j]), 64'(j == 3));
      end

    // 8-bit, 3-beat partial tail on NCH=1
    fmt[0] = 2'd1; rdy[0] = 1; clear_log(0);
    exp_w = '0;
    for (int b = 0; b < 3; b++) begin
      bt[b] = {96'd0, $urandom};
      exp_w[16*b +: 8]   = bt[b][11:4];
      exp_w[16*b+8 +: 8] = bt[b][27:20];
      din[0] = bt[b]; vld[0] = 1; lst[0] = (b == 2);
      tick();
    end
    vld[0] = 0; lst[0] = 0;
    tick(6);
    chk("b_words", 64'(wd[0].size()), 64'd1);
    if (wd[0].size() == 1) begin
      chk("b_data", wd[0][0], exp_w);
      chk("b_keep", 64'(wk[0][0]), 64'h3F);
      chk("b_last", 64'(wl[0][0]), 64'd1);
    end

    // 12-bit, 5-beat burst on NCH=2
    fmt[1] = 2'd2; clear_log(1);
    bits = '0;
    for (int b = 0; b < 5; b++) begin
      bt[b] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++)
        bits[48*b + 12*k +: 12] = bt[b][16*k +: 12];
      din[1] = bt[b]; vld[1] = 1; lst[1] = (b == 4);
      tick();
    end
    vld[1] = 0; lst[1] = 0;
    tick(8);
    chk("c_words", 64'(wd[1].size()), 64'd4);
    if (wd[1].size() == 4)
      for (int j = 0; j < 4; j++) begin
        chk("c_data", wd[1][j], bits[64*j +: 64]);
        chk("c_keep", 64'(wk[1][j]), (j == 3) ? 64'h3F : 64'hFF);
        chk("c_last", 64'(wl[1][j]), 64'(j == 3));
      end

    // NCH=4 overrun with a stalled output word
    rdy[2] = 0; fmt[2] = 2'd1; clear_log(2);
    din[2] = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 8; c++) exp8[8*c +: 8] = din[2][16*c+4 +: 8];
    vld[2] = 1; lst[2] = 1;
    tick();
    vld[2] = 0; lst[2] = 0;
    tick(3);
    fmt[2] = 2'd3;
    for (int b = 0; b < 3; b++) begin
      din[2] = {$urandom, $urandom, $urandom, $urandom};
      vld[2] = 1;
      tick();
    end
    vld[2] = 0;
    tick();
    chk("d_drop", 64'(dc[2]), 64'd2);
    chk("d_ovr", 64'(ov[2]), 64'd1);
    chk("d_hold_vld", 64'(tv[2]), 64'd1);
    chk("d_hold_data", td[2], exp8);
    chk("d_hold_last", 64'(tl[2]), 64'd1);
    clr[2] = 1;
    tick();
    clr[2] = 0;
    chk("d_clr_drop", 64'(dc[2]), 64'd0);
    chk("d_clr_ovr", 64'(ov[2]), 64'd0);

    // stop mid-burst while the word is still held
    fmt[2] = 2'd0; vld[2] = 1;
    tick(3);
    vld[2] = 0;
    chk("e_drop", 64'(dc[2]), 64'd0);
    chk("e_hold", 64'(tv[2]), 64'd1);
    rdy[2] = 1;
    tick(4);
    chk("e_words", 64'(wd[2].size()), 64'd1);
    if (wd[2].size() == 1) begin
      chk("e_data", wd[2][0], exp8);
      chk("e_last", 64'(wl[2][0]), 64'd1);
    end
    chk("e_idle", 64'(tv[2]), 64'd0);
    chk("e_drop2", 64'(dc[2]), 64'd0);

    // saturation of a 3-bit drop counter
    rdy[2] = 0; fmt[2] = 2'd3;
    for (int b = 0; b < 12; b++) begin
      din[2] = {$urandom, $urandom, $urandom, $urandom};
      vld[2] = 1;
      tick();
    end
    vld[2] = 0;
    chk("g_sat", 64'(dc[2]), 64'd7);
    chk("g_ovr", 64'(ov[2]), 64'd1);
    fmt[2] = 2'd0; rdy[2] = 1;
    tick(4);
    clr[2] = 1;
    tick();
    clr[2] = 0;

    // reset mid-burst, next burst aligned at byte 0
    fmt[1] = 2'd3; rdy[1] = 0;
    for (int b = 0; b < 2; b++) begin
      din[1] = {$urandom, $urandom, $urandom, $urandom};
      vld[1] = 1;
      tick();
    end
    vld[1] = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("f_rst_vld", 64'(tv[1]), 64'd0);
    clear_log(1); rdy[1] = 1;
    bt[0] = {$urandom, $urandom, $urandom, $urandom};
    din[1] = bt[0]; vld[1] = 1; lst[1] = 1;
    tick();
    vld[1] = 0; lst[1] = 0;
    tick(5);
    chk("f_words", 64'(wd[1].size()), 64'd1);
    if (wd[1].size() == 1) begin
      chk("f_data", wd[1][0], bt[0][63:0]);
      chk("f_keep", 64'(wk[1][0]), 64'hFF);
      chk("f_last", 64'(wl[1][0]), 64'd1);
    end

    // randomized traffic in lockstep with the model
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(63) == 0) fmt[i] = 2'($urandom_range(3));
        din[i] = {$urandom, $urandom, $urandom, $urandom};
        vld[i] = ($urandom_range(3) != 0);
        lst[i] = ($urandom_range(15) == 0);
        rdy[i] = ($urandom_range(3) != 0);
        clr[i] = ($urandom_range(199) == 0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vld[i] = 0; lst[i] = 0; clr[i] = 0; rdy[i] = 1;
    end
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
